mem_responder: RTL and testbench

Multi-cycle data-memory responder: the slave end of the load/store interface issued by the core's datapath. It accepts one request at a time over a valid/ready handshake and inserts a parameterised number of wait states. It performs byte/half/word loads (sign- or zero-extended) and stores with lane merging, then returns a one-cycle response pulse. It replaces the ideal single-cycle data memory when the core moves to stall-capable memory.

---
 rtl/mem_responder_pkg.sv | 25 ++
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder_lane_align.sv | 78 +++++++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the data-memory responder: funct3 size/sign codes,
// FSM states and a helper that classifies illegal funct3 values.
package mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic f3_illegal(input logic write, input logic [2:0] funct3);
    if (write) begin
      return (funct3 > F3_W);
    end
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request/response bundle between the core datapath (master)
// and the data-memory responder (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder_lane_align.sv
// mem_lane_align: combinational lane steering for the data-memory responder.
// Produces store byte enables and replicated write data, extracts and
// extends load lanes, and flags illegal or misaligned accesses.
// Build option: MEM_ALIGN_CHECK_EN -- when defined, misaligned half/word
// accesses are reported as errors; otherwise the address is forced aligned.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata,
  output logic        err
);

  logic        illegal;
  logic        misaligned;
  logic [1:0]  off;
  logic [31:0] shifted;

  // Classify the access, pick the byte offset, then steer lanes.
  always_comb begin
    illegal    = f3_illegal(write, funct3);
    misaligned = 1'b0;
    off        = addr;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr != 2'b00));
`else
    if (funct3[1:0] == 2'b01) begin
      off = {addr[1], 1'b0};
    end else if (funct3[1:0] == 2'b10) begin
      off = 2'b00;
    end
`endif
    err     = illegal | misaligned;
    shifted = rword >> {off, 3'b000};

    be         = 4'b0000;
    wdata_lane = 32'h0;
    rdata      = 32'h0;
    case (funct3)
      F3_B: begin
        rdata      = {{24{shifted[7]}}, shifted[7:0]};
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_H: begin
        rdata      = {{16{shifted[15]}}, shifted[15:0]};
        be         = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
      end
      F3_W: begin
        rdata      = shifted;
        be         = 4'b1111;
        wdata_lane = wdata;
      end
      F3_BU: rdata = {24'h0, shifted[7:0]};
      F3_HU: rdata = {16'h0, shifted[15:0]};
      default: begin
        rdata = 32'h0;
      end
    endcase

    // Errors neither write nor return data; loads never write, stores return 0.
    if (err || !write) begin
      be = 4'b0000;
    end
    if (err || write) begin
      rdata = 32'h0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle data-memory slave. Accepts one load/store at a
// time, waits WAIT_CYCLES cycles, performs the access on a byte-lane array
// and returns a one-cycle response pulse.
// Build option: MEM_ALIGN_CHECK_EN (see mem_lane_align) selects error
// reporting versus forced alignment for misaligned accesses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                ready_reg;
  logic                resp_valid_reg;
  logic [31:0]         resp_rdata_reg;
  logic                resp_err_reg;
  logic                lat_write;
  logic [2:0]          lat_funct3;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wdata;

  logic [ADDR_W-3:0]   word_idx;
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [31:0]         wdata_lane;
  logic [31:0]         al_rdata;
  logic                al_err;
  logic                access;
  logic                mem_we;

  assign word_idx = lat_addr[ADDR_W-1:2];
  assign access   = (state == WAIT) && (cnt == '0);
  assign mem_we   = access && lat_write;

  mem_lane_align u_align (
    .write      (lat_write),
    .funct3     (lat_funct3),
    .addr       (lat_addr[1:0]),
    .wdata      (lat_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata      (al_rdata),
    .err        (al_err)
  );

  // One byte-wide array per lane so partial stores need no read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Byte-lane write on the commit cycle; the array is never reset.
      always_ff @(posedge clk) begin
        if (mem_we && be[gi]) begin
          lane_mem[word_idx] <= wdata_lane[8*gi +: 8];
        end
      end

      assign rword[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // Request FSM: latch in IDLE, count wait states, commit and pulse response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      ready_reg      <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
      lat_write      <= 1'b0;
      lat_funct3     <= 3'b000;
      lat_addr       <= '0;
      lat_wdata      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_reg) begin
            lat_write  <= bus.req_write;
            lat_funct3 <= bus.req_funct3;
            lat_addr   <= bus.req_addr[ADDR_W-1:0];
            lat_wdata  <= bus.req_wdata;
            cnt        <= CNT_W'(WAIT_CYCLES);
            ready_reg  <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_rdata_reg <= al_rdata;
            resp_err_reg   <= al_err;
            resp_valid_reg <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          resp_valid_reg <= 1'b0;
          ready_reg      <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          resp_valid_reg <= 1'b0;
          ready_reg      <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance carries most
// vectors, a WAIT_CYCLES=0 instance checks the minimum latency.
// Expected values depend on MEM_ALIGN_CHECK_EN for misaligned vectors.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int WAIT_A = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  logic        valid = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        sel = 1'b0;

  assign bus.req_valid   = valid & ~sel;
  assign bus.req_write   = write;
  assign bus.req_funct3  = f3;
  assign bus.req_addr    = addr;
  assign bus.req_wdata   = wdata;
  assign bus0.req_valid  = valid & sel;
  assign bus0.req_write  = write;
  assign bus0.req_funct3 = f3;
  assign bus0.req_addr   = addr;
  assign bus0.req_wdata  = wdata;

  wire        ready      = sel ? bus0.req_ready  : bus.req_ready;
  wire        resp_valid = sel ? bus0.resp_valid : bus.resp_valid;
  wire [31:0] resp_rdata = sel ? bus0.resp_rdata : bus.resp_rdata;
  wire        resp_err   = sel ? bus0.resp_err   : bus.resp_err;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(WAIT_A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request from IDLE (called at posedge+1); returns at posedge+1 back in IDLE.
  task automatic txn(input logic wr, input logic [2:0] fn, input logic [31:0] a,
                     input logic [31:0] wd, input bit hold, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    lat   = 0;
    write = wr;
    f3    = fn;
    addr  = a;
    wdata = wd;
    valid = 1'b1;
    @(posedge clk); #1;
    check("ready_low", 32'(ready), 32'd0);
    if (hold) addr = a ^ 32'h44;
    else valid = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = i;
        break;
      end
      if (hold) check("hold_not_ready", 32'(ready), 32'd0);
    end
    valid = 1'b0;
    $display("txn wr=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             wr, fn, a, wd, resp_rdata, resp_err, lat);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", resp_rdata, exp_rd);
    check("err", 32'(resp_err), 32'(exp_err));
    @(posedge clk); #1;
    check("pulse_end", 32'(resp_valid), 32'd0);
    check("ready_back", 32'(ready), 32'd1);
  endtask

  localparam int L = WAIT_A + 1;

  initial begin
    logic [31:0] v;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    txn(1'b1, F3_W,  32'h10, 32'hDEADBEEF, 1'b0, L, 32'h0, 1'b0);
    txn(1'b0, F3_W,  32'h10, 32'h0,        1'b0, L, 32'hDEADBEEF, 1'b0);
    txn(1'b1, F3_B,  32'h11, 32'hAAAAAA55, 1'b0, L, 32'h0, 1'b0);
    txn(1'b0, F3_W,  32'h10, 32'h0,        1'b0, L, 32'hDEAD55EF, 1'b0);
    txn(1'b0, F3_B,  32'h11, 32'h0,        1'b0, L, 32'h00000055, 1'b0);
    txn(1'b0, F3_BU, 32'h13, 32'h0,        1'b0, L, 32'h000000DE, 1'b0);
    txn(1'b0, F3_B,  32'h13, 32'h0,        1'b0, L, 32'hFFFFFFDE, 1'b0);
    txn(1'b0, F3_H,  32'h12, 32'h0,        1'b0, L, 32'hFFFFDEAD, 1'b0);
    txn(1'b0, F3_HU, 32'h12, 32'h0,        1'b0, L, 32'h0000DEAD, 1'b0);
    txn(1'b0, F3_H,  32'h10, 32'h0,        1'b0, L, 32'h000055EF, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    txn(1'b0, F3_W,  32'h11, 32'h0,        1'b0, L, 32'h0, 1'b1);
    txn(1'b1, F3_W,  32'h12, 32'h12345678, 1'b0, L, 32'h0, 1'b1);
    v = 32'hDEAD55EF;
`else
    txn(1'b0, F3_W,  32'h11, 32'h0,        1'b0, L, 32'hDEAD55EF, 1'b0);
    txn(1'b1, F3_W,  32'h12, 32'h12345678, 1'b0, L, 32'h0, 1'b0);
    v = 32'h12345678;
`endif
    txn(1'b0, F3_W,  32'h10, 32'h0,        1'b0, L, v, 1'b0);

    // Illegal funct3 for load and store; store must not write.
    txn(1'b0, 3'b011, 32'h10, 32'h0,        1'b0, L, 32'h0, 1'b1);
    txn(1'b0, 3'b110, 32'h10, 32'h0,        1'b0, L, 32'h0, 1'b1);
    txn(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 1'b0, L, 32'h0, 1'b1);
    txn(1'b1, F3_BU,  32'h10, 32'hFFFFFFFF, 1'b0, L, 32'h0, 1'b1);
    txn(1'b0, F3_W,   32'h10, 32'h0,        1'b0, L, v, 1'b0);

    // Half store to the upper lane keeps the lower half.
    txn(1'b1, F3_H, 32'h12, 32'hFFFF8001, 1'b0, L, 32'h0, 1'b0);
    v = {16'h8001, v[15:0]};
    txn(1'b0, F3_W, 32'h10, 32'h0, 1'b0, L, v, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    txn(1'b0, F3_H, 32'h13, 32'h0, 1'b0, L, 32'h0, 1'b1);
`else
    txn(1'b0, F3_H, 32'h13, 32'h0, 1'b0, L, 32'hFFFF8001, 1'b0);
`endif

    // req_valid held through WAIT with a different address.
    txn(1'b0, F3_W, 32'h10, 32'h0, 1'b1, L, v, 1'b0);

    // Reset in WAIT discards the store and suppresses the response.
    txn(1'b1, F3_W, 32'h20, 32'hCAFEF00D, 1'b0, L, 32'h0, 1'b0);
    write = 1'b1; f3 = F3_W; addr = 32'h20; wdata = 32'h1; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check("rst_mid_accept", 32'(ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    $display("txn reset-in-wait store addr=00000020 -> resp_seen=%0d", seen);
    check("rst_no_resp", 32'(seen), 32'd0);
    check("rst_idle_ready", 32'(ready), 32'd1);
    check("rst_cleared_rdata", resp_rdata, 32'h0);
    txn(1'b0, F3_W, 32'h20, 32'h0, 1'b0, L, 32'hCAFEF00D, 1'b0);

    // Zero-wait instance: response one edge after accept.
    sel = 1'b1;
    txn(1'b1, F3_W, 32'h04, 32'hA5A5A5A5, 1'b0, 1, 32'h0, 1'b0);
    txn(1'b0, F3_B, 32'h04, 32'h0,        1'b0, 1, 32'hFFFFFFA5, 1'b0);
    txn(1'b0, F3_HU, 32'h06, 32'h0,       1'b0, 1, 32'h0000A5A5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
